// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-subset requests into words and drains them from a FIFO into instruction memory
module instr_encoder #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [3:0]  req_op,
   input  logic [4:0]  req_rs,
   input  logic [4:0]  req_rt,
   input  logic [4:0]  req_rd,
   input  logic [15:0] req_imm,
   input  logic [25:0] req_target,
   output logic        req_ready,
   input  logic        flush,
   output logic        im_we,
   output logic [31:0] im_addr,
   output logic [31:0] im_wdata,
   input  logic        im_ack,
   output logic        err,
   output logic [15:0] wr_cnt
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic [31:0]   addr, word;
   logic          legal, acc, push, pop, full, empty;
   assign full      = cnt == (AW+1)'(DEPTH);
   assign empty     = cnt == '0;
   assign req_ready = ~full;
   assign im_we     = ~empty;
   assign im_addr   = addr;
   // head is masked while empty so stale entries never reach the memory port
   assign im_wdata  = empty ? '0 : mem[rp];
   assign acc       = req_valid && req_ready && !flush;
   assign push      = acc && legal;
   assign pop       = im_we && im_ack && !flush;
   always_comb begin
      legal = 1'b1;
      word  = '0;
      case (req_op)
         4'd0:    word = '0;
         4'd1:    word = {6'h00, req_rs, req_rt, req_rd, 5'h0, 6'h21};
         4'd2:    word = {6'h00, req_rs, req_rt, req_rd, 5'h0, 6'h23};
         4'd3:    word = {6'h00, req_rs, 15'h0, 6'h08};
         4'd4:    word = {6'h0D, req_rs, req_rt, req_imm};
         4'd5:    word = {6'h23, req_rs, req_rt, req_imm};
         4'd6:    word = {6'h2B, req_rs, req_rt, req_imm};
         4'd7:    word = {6'h04, req_rs, req_rt, req_imm};
         4'd8:    word = {6'h0F, 5'h0, req_rt, req_imm};
         4'd9:    word = {6'h03, req_target};
         4'd10:   word = {6'h02, req_target};
         default: legal = 1'b0;
      endcase
   end
   always_ff @(posedge clk)
      if (push) mem[wp] <= word;
   always_ff @(posedge clk or posedge reset)
      if (reset || flush) begin
         wp     <= '0;
         rp     <= '0;
         cnt    <= '0;
         addr   <= BASE_ADDR;
         wr_cnt <= '0;
         err    <= 1'b0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) begin
            rp     <= rp + 1'b1;
            addr   <= addr + 32'd4;
            wr_cnt <= wr_cnt + 16'd1;
         end
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         err <= acc && !legal;
      end
endmodule
